mem_bus_master: RTL and testbench
=================================

Name: mem_bus_master

Overview:
- Data-memory access engine of the MEM stage.
- Takes load/store requests from EX (address = ALU result) and drives a single-outstanding req/ack data bus.
- Produces byte-lane enables and store data; aligns and sign-extends load data onto mem_data_to_gpr, which the MEM pipeline register captures.
- Stalls the pipeline while an access is in flight; flags misaligned, illegal and timed-out accesses.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, GPR/bus data width (fixed 32; 4 byte lanes).
- TIMEOUT, 255, max REQ cycles without bus_ack before bus error (8-bit counter).

Ports:
- clk  in  1  clock.
- reset  in  1  async active-low reset.
- ex_en  in  1  EX instruction valid.
- ex_load  in  1  instruction is a load.
- ex_store  in  1  instruction is a store.
- ex_funct3  in  3  width/sign code.
- ex_alu_out  in  ADDR_W  byte address.
- ex_store_data  in  DATA_W  rs2 value.
- mem_busy  out  1  pipeline stall (comb).
- mem_data_to_gpr  out  DATA_W  formatted load data (comb).
- misalign_exc  out  1  misaligned access pulse (comb).
- access_fault  out  1  illegal funct3 or timeout pulse (comb).
- fault_addr  out  ADDR_W  address of last faulting access (reg).
- bus_req  out  1  request (reg).
- bus_we  out  1  write (reg).
- bus_addr  out  ADDR_W-2  word address (reg).
- bus_be  out  4  byte enables (reg).
- bus_wdata  out  DATA_W  lane-replicated store data (reg).
- bus_ack  in  1  completion, 1-cycle pulse.
- bus_rdata  in  DATA_W  read word, valid with bus_ack.

Behaviour:
- Reset, async, active-low: all registered outputs 0, fault_addr 0, state IDLE, timeout counter 0. Reset asserted mid-access drops bus_req immediately and abandons the access.
- FSM has two states, IDLE and REQ.
- A request exists when ex_en && (ex_load || ex_store); load takes priority if both are high.
- Legal funct3:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
- Misaligned: half access with addr[0]=1; word access with addr[1:0]≠0.
- In IDLE with a request:
  - Illegal funct3: access_fault=1 this cycle, no bus activity, busy=0, fault_addr<=addr at the edge.
  - Else misaligned: misalign_exc=1 this cycle, no bus activity, busy=0, fault_addr<=addr at the edge.
  - Else accept: busy=1; at the edge bus_req<=1, bus_we<=store, bus_addr<=addr[ADDR_W-1:2]; latch funct3 and addr[1:0]; counter<=0; state->REQ.
- Byte enables: SB 0001<<a, SH 0011<<a, SW 1111, loads 1111.
- Store data: SB replicates byte ×4; SH replicates half ×2; SW as-is.
- In REQ:
  - bus_* are held stable until bus_ack.
  - mem_busy = !bus_ack && !timeout_hit.
  - On bus_ack (sampled high): busy=0 that cycle. For loads, mem_data_to_gpr = formatted bus_rdata in the same cycle. At the edge bus_req<=0 and state->IDLE.
  - Load formatting: select lane by latched a. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - When not a load-ack cycle, mem_data_to_gpr = 0.
  - counter increments each REQ cycle without ack. When counter==TIMEOUT-1 and no ack: access_fault=1, busy=0, mem_data_to_gpr=0, fault_addr<=latched full address, bus_req<=0, state->IDLE.
  - An ack arriving in the same cycle as the timeout wins; no fault is raised.
- Minimum access latency is 2 cycles (accept, then REQ+ack).
- Back-to-back accesses: a new request is accepted on the first cycle back in IDLE.
- Requests presented while in REQ are ignored; the pipeline is held by busy.
- No outputs are X after reset. bus_wdata is don't-care for loads but is driven deterministically with the replicated value.

Decomposition:
- Shared define.v gets:
  - funct3 codes (LB…SW);
  - FSM encodings (IDLE/REQ);
  - byte-enable width;
  - TIMEOUT default.
- One combinational sub-module, load_align: inputs rdata, funct3, addr[1:0]; output the formatted 32-bit word. Also reused by the verification model.

Test Plan:
- LW addr 0x100, ack after 3 REQ cycles, rdata 0xDEADBEEF: bus_addr=0x40, be=1111, busy high 3 cycles, mem_data_to_gpr=0xDEADBEEF in the ack cycle.
- LB addr 0x103, rdata 0x80FF0011 -> be=1111, data 0xFFFFFF80. Same access as LBU -> 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x21, data 0x123456AB -> bus_we=1, be=0010, wdata 0xABABABAB. SH addr 0x22, data 0x0000BEEF -> be=1100, wdata 0xBEEFBEEF.
- SW addr 0x102 -> misalign_exc 1 cycle, bus_req stays 0, fault_addr=0x102. Load funct3=011 -> access_fault, no request.
- Ack withheld, TIMEOUT=4 -> access_fault on the 4th REQ cycle, bus_req drops, FSM returns to IDLE. Ack on exactly that cycle -> normal completion, no fault.
- Reset asserted in REQ -> bus_req=0 asynchronously. After release, next LW completes normally. Back-to-back SW then LW -> second bus_req asserts the cycle after the first ack.

Source files
------------

// File: rtl/mem_bus_master_pkg.sv
// rtl/mem_bus_master_pkg.sv - funct3 codes, FSM encodings and lane helpers for the MEM-stage bus master
package mem_bus_master_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    localparam int BE_W            = 4;
    localparam int TIMEOUT_DEFAULT = 255;

    function automatic logic f3_legal(input logic load, input logic [2:0] f3);
        if (load)
            return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        return f3 inside {F3_SB, F3_SH, F3_SW};
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [BE_W-1:0] byte_enables(input logic load, input logic [2:0] f3,
                                                     input logic [1:0] a);
        if (load)
            return 4'b1111;
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// rtl/mem_bus_master_if.sv - single-outstanding req/ack data bus between MEM stage and memory
interface mem_bus_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-3:0] addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_bus_master_load_align.sv
// rtl/mem_bus_master_load_align.sv - selects the addressed lane of a read word and sign/zero-extends it
module mem_bus_master_load_align
    import mem_bus_master_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);
    logic [31:0] lane;

    always_comb begin
        lane = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_LB:   data = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   data = {{16{lane[15]}}, lane[15:0]};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'd0, lane[7:0]};
            F3_LHU:  data = {16'd0, lane[15:0]};
            default: data = '0;
        endcase
    end
endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - MEM-stage load/store engine driving a req/ack data bus with fault detection
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_en,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_store_data,
    output logic              mem_busy,
    output logic [DATA_W-1:0] mem_data_to_gpr,
    output logic              misalign_exc,
    output logic              access_fault,
    output logic [ADDR_W-1:0] fault_addr,
    mem_bus_master_if.master  bus
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [0:0]  state;
    logic [7:0]  cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;

    logic        req_valid;
    logic        legal;
    logic        misaligned;
    logic        in_idle;
    logic        accept;
    logic        reject_illegal;
    logic        reject_misalign;
    logic        timeout_hit;
    logic        load_ack;
    logic [31:0] aligned;

    assign req_valid  = ex_en && (ex_load || ex_store);
    assign legal      = f3_legal(ex_load, ex_funct3);
    assign misaligned = f3_misaligned(ex_funct3, ex_alu_out[1:0]);
    assign in_idle    = (state == ST_IDLE);

    assign reject_illegal  = in_idle && req_valid && !legal;
    assign reject_misalign = in_idle && req_valid && legal && misaligned;
    assign accept          = in_idle && req_valid && legal && !misaligned;

    // An ack landing on the last allowed cycle completes the access instead of faulting
    assign timeout_hit = (state == ST_REQ) && !bus.ack && (cnt == CNT_LAST);
    assign load_ack    = (state == ST_REQ) && bus.ack && !bus.we;

    mem_bus_master_load_align u_load_align (
        .rdata   (bus.rdata),
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .data    (aligned)
    );

    assign mem_busy        = in_idle ? accept : (!bus.ack && !timeout_hit);
    assign mem_data_to_gpr = load_ack ? aligned : '0;
    assign misalign_exc    = reject_misalign;
    assign access_fault    = reject_illegal || timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            fault_addr <= '0;
            bus.req    <= 1'b0;
            bus.we     <= 1'b0;
            bus.addr   <= '0;
            bus.be     <= '0;
            bus.wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (reject_illegal || reject_misalign)
                        fault_addr <= ex_alu_out;
                    if (accept) begin
                        bus.req   <= 1'b1;
                        bus.we    <= !ex_load;
                        bus.addr  <= ex_alu_out[ADDR_W-1:2];
                        bus.be    <= byte_enables(ex_load, ex_funct3, ex_alu_out[1:0]);
                        bus.wdata <= store_lanes(ex_funct3, ex_store_data);
                        funct3_q  <= ex_funct3;
                        addr_lo_q <= ex_alu_out[1:0];
                        cnt       <= '0;
                        state     <= ST_REQ;
                    end
                end
                default: begin
                    if (bus.ack) begin
                        bus.req <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (timeout_hit) begin
                        fault_addr <= {bus.addr, addr_lo_q};
                        bus.req    <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - directed scoreboard bench for mem_bus_master
module tb_mem_bus_master;
    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        ex_en;
    logic        ex_load;
    logic        ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_store_data;
    logic        mem_busy;
    logic [31:0] mem_data_to_gpr;
    logic        misalign_exc;
    logic        access_fault;
    logic [31:0] fault_addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] be;
        logic [31:0] wdata;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];

    mem_bus_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .ex_en           (ex_en),
        .ex_load         (ex_load),
        .ex_store        (ex_store),
        .ex_funct3       (ex_funct3),
        .ex_alu_out      (ex_alu_out),
        .ex_store_data   (ex_store_data),
        .mem_busy        (mem_busy),
        .mem_data_to_gpr (mem_data_to_gpr),
        .misalign_exc    (misalign_exc),
        .access_fault    (access_fault),
        .fault_addr      (fault_addr),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after completion, so calls chain back-to-back.
    // ack_cyc is the REQ cycle carrying bus_ack (0 = never, expect timeout).
    task automatic access(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int ack_cyc, input logic [31:0] rd,
                          input logic [3:0] ebe, input logic [31:0] ewdata,
                          input logic [31:0] edata);
        exp_t e;
        ex_en = 1'b1; ex_load = ld; ex_store = !ld; ex_funct3 = f3;
        ex_alu_out = a; ex_store_data = sd;
        sb_q.push_back('{we: !ld, addr: a >> 2, be: 32'(ebe), wdata: ewdata, data: edata});
        #1;
        chk("accept_busy", 32'(mem_busy), 32'd1);
        chk("accept_nofault", 32'({misalign_exc, access_fault}), 32'd0);
        @(negedge clk);
        ex_en = 1'b0;
        for (int cyc = 1; cyc <= TO; cyc++) begin
            bus.ack = (cyc == ack_cyc);
            bus.rdata = rd;
            #1;
            if (cyc == 1) begin
                e = sb_q.pop_front();
                chk("bus_req", 32'(bus.req), 32'd1);
                chk("bus_we", 32'(bus.we), 32'(e.we));
                chk("bus_addr", 32'(bus.addr), e.addr);
                chk("bus_be", 32'(bus.be), e.be);
                chk("bus_wdata", bus.wdata, e.wdata);
            end
            if (cyc == ack_cyc) begin
                chk("ack_busy", 32'(mem_busy), 32'd0);
                chk("ack_fault", 32'(access_fault), 32'd0);
                chk("ack_data", mem_data_to_gpr, e.data);
                @(negedge clk);
                bus.ack = 1'b0;
                chk("post_ack_req", 32'(bus.req), 32'd0);
                break;
            end else if (cyc == TO) begin
                chk("timeout_fault", 32'(access_fault), 32'd1);
                chk("timeout_busy", 32'(mem_busy), 32'd0);
                chk("timeout_data", mem_data_to_gpr, 32'd0);
                @(negedge clk);
                chk("timeout_req", 32'(bus.req), 32'd0);
                chk("timeout_addr", fault_addr, a);
            end else begin
                chk("wait_busy", 32'(mem_busy), 32'd1);
                chk("wait_fault", 32'(access_fault), 32'd0);
                chk("wait_data", mem_data_to_gpr, 32'd0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        ex_en = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b000;
        ex_alu_out = '0; ex_store_data = '0;
        bus.ack = 1'b0; bus.rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus.req), 32'd0);
        chk("rst_be", 32'(bus.be), 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_fault_addr", fault_addr, 32'd0);
        chk("rst_busy", 32'(mem_busy), 32'd0);
        chk("rst_data", mem_data_to_gpr, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        access(1'b1, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
        access(1'b1, 3'b000, 32'h103, 32'h0, 1, 32'h80FF0011, 4'b1111, 32'h0, 32'hFFFFFF80);
        access(1'b1, 3'b100, 32'h103, 32'h0, 1, 32'h80FF0011, 4'b1111, 32'h0, 32'h00000080);
        access(1'b1, 3'b001, 32'h102, 32'h0, 2, 32'h80FF0011, 4'b1111, 32'h0, 32'hFFFF80FF);
        access(1'b1, 3'b101, 32'h102, 32'h0, 1, 32'h80FF0011, 4'b1111, 32'h0, 32'h000080FF);
        access(1'b0, 3'b000, 32'h21, 32'h123456AB, 1, 32'h0, 4'b0010, 32'hABABABAB, 32'h0);
        access(1'b0, 3'b001, 32'h22, 32'h0000BEEF, 2, 32'h0, 4'b1100, 32'hBEEFBEEF, 32'h0);

        ex_en = 1'b1; ex_load = 1'b0; ex_store = 1'b1; ex_funct3 = 3'b010; ex_alu_out = 32'h102;
        #1;
        chk("mis_exc", 32'(misalign_exc), 32'd1);
        chk("mis_busy", 32'(mem_busy), 32'd0);
        @(negedge clk);
        ex_en = 1'b0;
        #1;
        chk("mis_req", 32'(bus.req), 32'd0);
        chk("mis_fault_addr", fault_addr, 32'h102);
        chk("mis_exc_clear", 32'(misalign_exc), 32'd0);

        @(negedge clk);
        ex_en = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b011; ex_alu_out = 32'h200;
        #1;
        chk("ill_fault", 32'(access_fault), 32'd1);
        chk("ill_busy", 32'(mem_busy), 32'd0);
        chk("ill_mis", 32'(misalign_exc), 32'd0);
        @(negedge clk);
        ex_en = 1'b0;
        #1;
        chk("ill_req", 32'(bus.req), 32'd0);
        chk("ill_fault_addr", fault_addr, 32'h200);
        @(negedge clk);

        access(1'b1, 3'b010, 32'h300, 32'h0, 0, 32'h0, 4'b1111, 32'h0, 32'h0);
        access(1'b1, 3'b010, 32'h304, 32'h0, TO, 32'h55AA1234, 4'b1111, 32'h0, 32'h55AA1234);
        chk("late_ack_fault_addr", fault_addr, 32'h300);

        ex_en = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010; ex_alu_out = 32'h400;
        @(negedge clk);
        ex_en = 1'b0;
        #1;
        chk("midrst_req_before", 32'(bus.req), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_req", 32'(bus.req), 32'd0);
        chk("midrst_busy", 32'(mem_busy), 32'd0);
        chk("midrst_fault_addr", fault_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        access(1'b1, 3'b010, 32'h500, 32'h0, 1, 32'h01020304, 4'b1111, 32'h0, 32'h01020304);

        access(1'b0, 3'b010, 32'h10, 32'hCAFEF00D, 1, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0);
        access(1'b1, 3'b010, 32'h14, 32'h0, 1, 32'h0BADF00D, 4'b1111, 32'h0, 32'h0BADF00D);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
